// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter shared types: FSM state encoding and header tag.
// Imported by the arbiter top.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      KICK,
      WAIT
   } arb_state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter bus: requester byte streams plus UART TX FIFO port.
// master = clients/UART side, slave = arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 8
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            grant;
   logic                          tx_full;
   logic                          tx_done;
   logic                          tx_wen;
   logic [FIFO_WIDTH-1:0]         tx_write_data;
   logic                          tx_begin;
   logic                          busy;

   modport master (
      output req_valid, req_data, req_last,
      output tx_full, tx_done,
      input  req_ready, grant, tx_wen,
      input  tx_write_data, tx_begin, busy
   );

   modport slave (
      input  req_valid, req_data, req_last,
      input  tx_full, tx_done,
      output req_ready, grant, tx_wen,
      output tx_write_data, tx_begin, busy
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above ptr_i, with wrap.
// Purely combinational.
module rr_picker #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   // Scan NUM_REQ slots starting at the pointer, keep the first hit
   always_comb begin
      int j;
      j      = 0;
      pick_o = '0;
      idx_o  = '0;
      any_o  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr_i) + k) % NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o     = 1'b1;
            pick_o[j] = 1'b1;
            idx_o     = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding the UART TX FIFO.
// Optional header byte per packet: define UART_ARB_ID_HDR_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 8,
   parameter int MAX_PKT    = 16
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_PKT + 1);

   arb_state_t         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [IW-1:0]      rr_q, rr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               full_q;

   logic [NUM_REQ-1:0]    pick;
   logic [IW-1:0]         pick_idx;
   logic                  pick_any;
   logic                  sel_valid;
   logic                  sel_last;
   logic [FIFO_WIDTH-1:0] sel_data;
   logic                  accept;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i  (bus.req_valid),
      .ptr_i  (rr_q),
      .pick_o (pick),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   assign sel_valid = bus.req_valid[gidx_q];
   assign sel_last  = bus.req_last[gidx_q];
   assign sel_data  = bus.req_data[gidx_q*FIFO_WIDTH +: FIFO_WIDTH];

   assign bus.grant = grant_q;
   assign bus.busy  = (state_q != IDLE);

   // Next state, handshake muxing and write-port drive
   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      gidx_d            = gidx_q;
      rr_d              = rr_q;
      cnt_d             = cnt_q;
      accept            = 1'b0;
      bus.req_ready     = '0;
      bus.tx_wen        = 1'b0;
      bus.tx_write_data = '0;
      bus.tx_begin      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick;
               gidx_d  = pick_idx;
`ifdef UART_ARB_ID_HDR_EN
               state_d = HDR;
`else
               state_d = DATA;
`endif
            end
         end
         HDR: begin
`ifdef UART_ARB_ID_HDR_EN
            bus.tx_wen        = !bus.tx_full;
            bus.tx_write_data =
               FIFO_WIDTH'({HDR_TAG, 4'(gidx_q)});
            if (!bus.tx_full) begin
               state_d = DATA;
            end
`else
            grant_d = '0;
            state_d = IDLE;
`endif
         end
         DATA: begin
            accept            = sel_valid && !bus.tx_full;
            bus.req_ready     = grant_q & {NUM_REQ{!bus.tx_full}};
            bus.tx_wen        = accept;
            bus.tx_write_data = sel_data;
            bus.tx_begin      = bus.tx_full && !full_q;
            if (accept) begin
               if (sel_last || cnt_q == CW'(MAX_PKT - 1)) begin
                  cnt_d   = '0;
                  state_d = KICK;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         KICK: begin
            bus.tx_begin = 1'b1;
            rr_d = (gidx_q == IW'(NUM_REQ - 1)) ?
                   '0 : gidx_q + 1'b1;
            if (bus.tx_done) begin
               grant_d = '0;
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.tx_done) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, ownership, pointer, count and tx_full history registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         full_q  <= bus.tx_full;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus random
// packet traffic checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int NR   = 4;
   localparam int W    = 8;
   localparam int MAXP = 16;
`ifdef UART_ARB_ID_HDR_EN
   localparam int HB = 1;
`else
   localparam int HB = 0;
`endif

   typedef logic [7:0] byte_q_t[$];
   typedef int int_q_t[$];

   logic clk;
   logic rst;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(W)) bus();

   uart_tx_arbiter #(
      .NUM_REQ    (NR),
      .FIFO_WIDTH (W),
      .MAX_PKT    (MAXP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   logic [7:0] q_d[NR][$];
   bit         q_l[NR][$];
   logic [7:0] m_d[NR][$];
   bit         m_l[NR][$];

   byte_q_t exp_b;
   int_q_t  exp_g;
   int_q_t  exp_k;
   byte_q_t wr_log;
   int_q_t  grant_log;
   int_q_t  kick_log;

   bit   rst_v;
   bit   full_force;
   int   full_pct;
   int   done_pct;
   int   nbegin;
   int   nacc[NR];
   int   full_viol;
   int   gr_viol;
   logic [NR-1:0] prev_grant;

   function automatic int oh2i(logic [NR-1:0] g);
      int r = -1;
      for (int i = 0; i < NR; i++) if (g[i]) r = i;
      return r;
   endfunction

   function automatic int diff_b(byte_q_t a, byte_q_t b);
      int d = (a.size() != b.size()) ? 1 : 0;
      for (int i = 0; i < a.size() && i < b.size(); i++)
         if (a[i] !== b[i]) d++;
      return d;
   endfunction

   function automatic int diff_i(int_q_t a, int_q_t b);
      int d = (a.size() != b.size()) ? 1 : 0;
      for (int i = 0; i < a.size() && i < b.size(); i++)
         if (a[i] != b[i]) d++;
      return d;
   endfunction

   // Packet-level model: round robin over non-empty requesters,
   // each grant emits (header) + bytes up to last or MAXP.
   function automatic void build_model(int rr0);
      int rr = rr0;
      int g;
      int n;
      bit fin;
      bit l;
      logic [7:0] b;
      exp_b.delete();
      exp_g.delete();
      exp_k.delete();
      for (int i = 0; i < NR; i++) begin
         m_d[i] = q_d[i];
         m_l[i] = q_l[i];
      end
      forever begin
         g = -1;
         for (int k = 0; k < NR; k++)
            if (g < 0 && m_d[(rr + k) % NR].size() > 0) g = (rr + k) % NR;
         if (g < 0) break;
         exp_g.push_back(g);
         if (HB == 1) exp_b.push_back(8'hA0 | 8'(g));
         n = 0;
         fin = 0;
         while (!fin) begin
            b = m_d[g].pop_front();
            l = m_l[g].pop_front();
            exp_b.push_back(b);
            n++;
            if (l || n == MAXP || m_d[g].size() == 0) fin = 1;
         end
         exp_k.push_back(exp_b.size());
         rr = (g + 1) % NR;
      end
   endfunction

   task automatic push(input int r, input logic [7:0] b, input bit l);
      q_d[r].push_back(b);
      q_l[r].push_back(l);
   endtask

   task automatic clear_logs();
      wr_log.delete();
      grant_log.delete();
      kick_log.delete();
      nbegin = 0;
      full_viol = 0;
      gr_viol = 0;
      prev_grant = '0;
      for (int i = 0; i < NR; i++) nacc[i] = 0;
   endtask

   // One clock: drive at negedge, observe 1ns later, consume accepts
   task automatic cyc();
      bit v;
      @(negedge clk);
      rst = rst_v;
      for (int i = 0; i < NR; i++) begin
         v = rst_v && (q_d[i].size() > 0);
         bus.req_valid[i] = v;
         bus.req_data[i*W +: W] = 8'h00;
         bus.req_last[i] = 1'b0;
         if (v) begin
            bus.req_data[i*W +: W] = q_d[i][0];
            bus.req_last[i] = q_l[i][0];
         end
      end
      bus.tx_full = full_force ||
                    (full_pct > 0 && $urandom_range(0, 99) < full_pct);
      bus.tx_done = ($urandom_range(0, 99) < done_pct);
      #1;
      if (bus.tx_wen) wr_log.push_back(bus.tx_write_data);
      if (bus.tx_begin) begin
         nbegin++;
         kick_log.push_back(wr_log.size());
      end
      if (bus.tx_full && (bus.req_ready != 0 || bus.tx_wen)) full_viol++;
      if (!$onehot0(bus.grant) || (!bus.busy && bus.grant != 0)) gr_viol++;
      if (bus.grant != 0 && prev_grant == 0)
         grant_log.push_back(oh2i(bus.grant));
      prev_grant = bus.grant;
      for (int i = 0; i < NR; i++)
         if (bus.req_valid[i] && bus.req_ready[i]) begin
            void'(q_d[i].pop_front());
            void'(q_l[i].pop_front());
            nacc[i]++;
         end
   endtask

   task automatic drain(input int budget, output bit ok);
      bit empty;
      ok = 0;
      for (int n = 0; n < budget; n++) begin
         cyc();
         empty = 1;
         for (int i = 0; i < NR; i++) if (q_d[i].size() > 0) empty = 0;
         if (empty && !bus.busy) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < NR; i++) begin
         q_d[i].delete();
         q_l[i].delete();
      end
      full_force = 0;
      full_pct = 0;
      rst_v = 0;
      repeat (2) cyc();
      rst_v = 1;
      clear_logs();
   endtask

   task automatic test_reset();
      do_reset();
      ntests++;
      if (bus.grant !== '0 || bus.req_ready !== '0 || bus.busy !== 1'b0) begin
         nfail++;
         $display("FAIL reset_ctrl: grant=%b ready=%b busy=%b need 0",
                  bus.grant, bus.req_ready, bus.busy);
      end
      ntests++;
      if (bus.tx_wen !== 1'b0 || bus.tx_begin !== 1'b0 ||
          bus.tx_write_data !== 8'h00) begin
         nfail++;
         $display("FAIL reset_tx: wen=%b begin=%b data=%h need 0/0/00",
                  bus.tx_wen, bus.tx_begin, bus.tx_write_data);
      end
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      done_pct = 100;
      push(0, 8'h11, 0);
      push(0, 8'h22, 0);
      push(0, 8'h33, 1);
      build_model(0);
      drain(200, ok);
      ntests++;
      if (ok !== 1'b1) begin
         nfail++;
         $display("FAIL single_done: drained=%0d need 1", ok);
      end
      ntests++;
      if (wr_log.size() != 3 + HB || diff_b(wr_log, exp_b) != 0) begin
         nfail++;
         $display("FAIL single_stream: got %0d bytes (%0d diffs) need %0d",
                  wr_log.size(), diff_b(wr_log, exp_b), 3 + HB);
      end
      ntests++;
      if (wr_log.size() > HB && wr_log[HB] !== 8'h11) begin
         nfail++;
         $display("FAIL single_first: got %h need 11", wr_log[HB]);
      end
      ntests++;
      if (nbegin != 1) begin
         nfail++;
         $display("FAIL single_begin: got %0d pulses need 1", nbegin);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      done_pct = 50;
      push(1, 8'hA1, 0);
      push(1, 8'hA2, 1);
      push(1, 8'hA3, 1);
      push(2, 8'hB1, 0);
      push(2, 8'hB2, 1);
      build_model(0);
      drain(300, ok);
      ntests++;
      if (ok !== 1'b1) begin
         nfail++;
         $display("FAIL b2b_done: drained=%0d need 1", ok);
      end
      ntests++;
      if (grant_log.size() != 3 || grant_log[0] != 1 ||
          grant_log[1] != 2 || grant_log[2] != 1) begin
         nfail++;
         $display("FAIL b2b_order: got %p need '{1,2,1}", grant_log);
      end
      ntests++;
      if (diff_b(wr_log, exp_b) != 0) begin
         nfail++;
         $display("FAIL b2b_stream: got %p need %p", wr_log, exp_b);
      end
   endtask

   task automatic test_full();
      bit ok;
      int n = 0;
      do_reset();
      done_pct = 100;
      for (int k = 0; k < 6; k++) push(0, 8'(8'h40 + k), k == 5);
      build_model(0);
      while (nacc[0] < 2 && n < 100) begin
         cyc();
         n++;
      end
      ntests++;
      if (nacc[0] != 2) begin
         nfail++;
         $display("FAIL full_start: accepted %0d need 2", nacc[0]);
      end
      full_force = 1;
      repeat (5) cyc();
      full_force = 0;
      drain(200, ok);
      ntests++;
      if (ok !== 1'b1 || full_viol != 0) begin
         nfail++;
         $display("FAIL full_hold: drained=%0d viol=%0d need 1/0",
                  ok, full_viol);
      end
      ntests++;
      if (diff_b(wr_log, exp_b) != 0) begin
         nfail++;
         $display("FAIL full_stream: got %p need %p", wr_log, exp_b);
      end
      ntests++;
      if (nbegin != 2) begin
         nfail++;
         $display("FAIL full_begin: got %0d pulses need 2", nbegin);
      end
   endtask

   task automatic test_maxpkt();
      bit ok;
      do_reset();
      done_pct = 100;
      for (int k = 0; k < 20; k++) push(0, 8'(k + 1), k == 19);
      push(1, 8'hC1, 0);
      push(1, 8'hC2, 1);
      build_model(0);
      drain(400, ok);
      ntests++;
      if (ok !== 1'b1) begin
         nfail++;
         $display("FAIL max_done: drained=%0d need 1", ok);
      end
      ntests++;
      if (kick_log.size() == 0 || kick_log[0] != 16 + HB) begin
         nfail++;
         $display("FAIL max_kick16: got %p need first %0d",
                  kick_log, 16 + HB);
      end
      ntests++;
      if (diff_i(kick_log, exp_k) != 0 || diff_i(grant_log, exp_g) != 0) begin
         nfail++;
         $display("FAIL max_grants: kicks %p need %p grants %p need %p",
                  kick_log, exp_k, grant_log, exp_g);
      end
      ntests++;
      if (diff_b(wr_log, exp_b) != 0) begin
         nfail++;
         $display("FAIL max_stream: %0d diffs", diff_b(wr_log, exp_b));
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n = 0;
      do_reset();
      done_pct = 100;
      push(1, 8'h71, 1);
      drain(100, ok);
      for (int k = 0; k < 5; k++) push(2, 8'(8'h80 + k), k == 4);
      clear_logs();
      while (nacc[2] < 2 && n < 100) begin
         cyc();
         n++;
      end
      ntests++;
      if (ok !== 1'b1 || nacc[2] != 2) begin
         nfail++;
         $display("FAIL rmid_setup: drained=%0d acc=%0d need 1/2",
                  ok, nacc[2]);
      end
      rst_v = 0;
      cyc();
      rst_v = 1;
      clear_logs();
      push(1, 8'h72, 1);
      build_model(0);
      cyc();
      ntests++;
      if (bus.grant !== '0 || bus.req_ready !== '0 || bus.busy !== 1'b0 ||
          bus.tx_wen !== 1'b0 || bus.tx_begin !== 1'b0) begin
         nfail++;
         $display("FAIL rmid_zero: g=%b r=%b busy=%b wen=%b beg=%b need 0",
                  bus.grant, bus.req_ready, bus.busy,
                  bus.tx_wen, bus.tx_begin);
      end
      drain(200, ok);
      ntests++;
      if (ok !== 1'b1 || grant_log.size() == 0 || grant_log[0] != 1) begin
         nfail++;
         $display("FAIL rmid_rr: drained=%0d grants %p need first 1",
                  ok, grant_log);
      end
      ntests++;
      if (diff_b(wr_log, exp_b) != 0) begin
         nfail++;
         $display("FAIL rmid_stream: got %p need %p", wr_log, exp_b);
      end
   endtask

   task automatic test_hdr();
      bit ok;
      do_reset();
      done_pct = 100;
      push(3, 8'h55, 1);
      drain(100, ok);
      ntests++;
      if (ok !== 1'b1 || wr_log.size() != 1 + HB) begin
         nfail++;
         $display("FAIL hdr_len: drained=%0d bytes=%0d need %0d",
                  ok, wr_log.size(), 1 + HB);
      end
      ntests++;
      if (wr_log.size() == 1 + HB &&
          (wr_log[HB] !== 8'h55 || (HB == 1 && wr_log[0] !== 8'hA3))) begin
         nfail++;
         $display("FAIL hdr_bytes: got %p need %s", wr_log,
                  (HB == 1) ? "a3 55" : "55");
      end
   endtask

   task automatic test_random();
      bit ok;
      int np;
      int len;
      for (int round = 0; round < 20; round++) begin
         do_reset();
         full_pct = 20;
         done_pct = 30;
         for (int r = 0; r < NR; r++) begin
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(1, 20);
               for (int k = 0; k < len; k++)
                  push(r, 8'($urandom), k == len - 1);
            end
         end
         build_model(0);
         drain(4000, ok);
         full_pct = 0;
         ntests++;
         if (ok !== 1'b1) begin
            nfail++;
            $display("FAIL rand_done[%0d]: drained=%0d need 1", round, ok);
         end
         ntests++;
         if (diff_b(wr_log, exp_b) != 0) begin
            nfail++;
            $display("FAIL rand_stream[%0d]: %0d diffs, %0d vs %0d bytes",
                     round, diff_b(wr_log, exp_b),
                     wr_log.size(), exp_b.size());
         end
         ntests++;
         if (diff_i(grant_log, exp_g) != 0) begin
            nfail++;
            $display("FAIL rand_grants[%0d]: got %p need %p",
                     round, grant_log, exp_g);
         end
         ntests++;
         if (full_viol != 0 || gr_viol != 0) begin
            nfail++;
            $display("FAIL rand_inv[%0d]: full=%0d grant=%0d need 0/0",
                     round, full_viol, gr_viol);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      rst_v = 0;
      full_force = 0;
      full_pct = 0;
      done_pct = 100;
      bus.req_valid = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      bus.tx_full = 1'b0;
      bus.tx_done = 1'b0;
      clear_logs();
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_maxpkt();
      test_reset_mid();
      test_hdr();
      test_random();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
